fifoin_burst_reader: RTL and testbench

FIFOIN_BURST_READER -- requirements
Module: fifoin_burst_reader

---
 rtl/fifoin_pkg.sv | 25 ++
 rtl/fifoin_skid_buf.sv | 66 ++++++
 rtl/fifoin_burst_reader.sv | 158 +++++++++++++++
 tb/tb_fifoin_burst_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifoin_pkg.sv
// Shared types and default parameters for the FIFO-to-burst reader.
package fifoin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH   = 256;
    localparam int DEF_LEVEL_WIDTH  = 8;
    localparam int DEF_BURST_LEN    = 16;
    localparam int DEF_ADDR_WIDTH   = 28;
    localparam int DEF_FRAME_BURSTS = 1024;

    localparam int BYTES_PER_WORD   = DEF_DATA_WIDTH / 8;

    // Word counters must hold BURST_LEN itself (up to 64).
    localparam int CNT_W = 7;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/fifoin_skid_buf.sv
// Two-entry output buffer: absorbs the word already in flight from the FIFO
// when the downstream stalls. Head entry is always the oldest word.
module fifoin_skid_buf #(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  do_pop;

    // Next buffer contents for every push/pop combination.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != 2'd0);
        case ({push_i, do_pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = push_data_i;
                else                 tail_d = push_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    // Buffer storage; entries clear on reset so the data output reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fifoin_burst_reader.sv
// Drains fixed-length bursts from a FIFO: issues one address command per
// burst, then streams BURST_LEN words with a 2-entry output buffer.
//
// state   | meaning
// IDLE    | waiting for FIFO level >= BURST_LEN
// CMD     | presenting burst command, waiting for cmd_ready
// DATA    | reading BURST_LEN words and streaming them out
module fifoin_burst_reader
    import fifoin_pkg::*;
#(
    parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int                    LEVEL_WIDTH  = DEF_LEVEL_WIDTH,
    parameter int                    BURST_LEN    = DEF_BURST_LEN,
    parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    FRAME_BURSTS = DEF_FRAME_BURSTS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   rd_en,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   rd_empty,
    input  logic [LEVEL_WIDTH-1:0] rd_water_level,
    input  logic                   frame_sync,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [ADDR_WIDTH-1:0]  cmd_addr,
    output logic [7:0]             cmd_len,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_last,
    output logic                   busy
);

    localparam int                    BC_W      = $clog2(FRAME_BURSTS + 1);
    localparam logic [CNT_W-1:0]       LEN_C     = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]       LAST_C    = CNT_W'(BURST_LEN - 1);
    localparam logic [LEVEL_WIDTH-1:0] LVL_C     = LEVEL_WIDTH'(BURST_LEN);
    localparam logic [BC_W-1:0]        BC_LAST   = BC_W'(FRAME_BURSTS - 1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_STEP =
        ADDR_WIDTH'(BURST_LEN * bytes_per_word(DATA_WIDTH));

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BC_W-1:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  sync_pend_q, sync_pend_d;
    logic                  inflight_q;
    logic [1:0]            buf_count;
    logic [2:0]            pending;
    logic                  pop, cmd_fire, burst_done;

    assign pop        = m_valid && m_ready;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign m_last     = m_valid && (beat_cnt_q == LAST_C);
    assign burst_done = pop && m_last;
    assign cmd_addr   = addr_q;
    assign cmd_len    = 8'(BURST_LEN - 1);

    // Words that will occupy the buffer after this cycle's pop; the pop is
    // credited so a full-rate stream keeps one read in flight every cycle.
    assign pending = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rd_water_level >= LVL_C) state_d = ST_CMD;
            ST_CMD:  if (cmd_ready)               state_d = ST_DATA;
            ST_DATA: if (burst_done)              state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, including the FIFO read strobe.
    always_comb begin
        cmd_valid = (state_q == ST_CMD);
        busy      = (state_q != ST_IDLE);
        rd_en     = (state_q == ST_DATA) && (rd_cnt_q < LEN_C) &&
                    !rd_empty && (pending < 3'd2);
    end

    // Word counters, frame address/burst tracking and deferred frame restart.
    always_comb begin
        addr_d      = addr_q;
        bcnt_d      = bcnt_q;
        sync_pend_d = sync_pend_q;
        rd_cnt_d    = rd_cnt_q;
        beat_cnt_d  = beat_cnt_q;

        if (cmd_fire) begin
            rd_cnt_d   = '0;
            beat_cnt_d = '0;
        end else begin
            if (rd_en) rd_cnt_d   = rd_cnt_q + CNT_W'(1);
            if (pop)   beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end

        if (state_q == ST_IDLE) begin
            if (frame_sync) begin
                addr_d = BASE_ADDR;
                bcnt_d = '0;
            end
        end else if (burst_done) begin
            sync_pend_d = 1'b0;
            if (sync_pend_q || frame_sync || (bcnt_q == BC_LAST)) begin
                addr_d = BASE_ADDR;
                bcnt_d = '0;
            end else begin
                addr_d = addr_q + ADDR_STEP;
                bcnt_d = bcnt_q + BC_W'(1);
            end
        end else if (frame_sync) begin
            sync_pend_d = 1'b1;
        end
    end

    // Datapath and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= BASE_ADDR;
            bcnt_q      <= '0;
            sync_pend_q <= 1'b0;
            rd_cnt_q    <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            bcnt_q      <= bcnt_d;
            sync_pend_q <= sync_pend_d;
            rd_cnt_q    <= rd_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= rd_en;
        end
    end

    fifoin_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (rd_data),
        .pop_i       (pop),
        .valid_o     (m_valid),
        .data_o      (m_data),
        .count_o     (buf_count)
    );

endmodule

// File: tb/tb_fifoin_burst_reader.sv
// Bench for fifoin_burst_reader: FIFO model, scoreboard of expected words
// and command addresses, and a negedge monitor.
module tb_fifoin_burst_reader;

    localparam int DW = 256;
    localparam int LW = 8;
    localparam int AW = 28;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          rd_empty;
    logic [LW-1:0] rd_water_level;
    logic          frame_sync;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    always #5 clk = ~clk;

    fifoin_burst_reader #(
        .DATA_WIDTH   (DW),
        .LEVEL_WIDTH  (LW),
        .BURST_LEN    (16),
        .ADDR_WIDTH   (AW),
        .BASE_ADDR    ('0),
        .FRAME_BURSTS (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .frame_sync     (frame_sync),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .busy           (busy)
    );

    // FIFO model: stimulus owns wr_ptr/mem, the read side owns rd_ptr.
    logic [DW-1:0] mem [0:511];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign rd_empty       = (wr_ptr == rd_ptr);
    assign rd_water_level = LW'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_ptr % 512];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues.
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor state.
    int            n_deliv = 0;
    int            bbeat = 0;
    int            bursts_done = 0;
    int            hs_cyc = 0;
    int            first_cyc = 0;
    int            last_cyc = 0;
    bit            first_pending = 0;
    bit            prev_mv_stall = 0;
    bit            prev_cmd_stall = 0;
    logic [DW-1:0] prev_md = '0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            // Words read but not delivered are lost with the aborted burst.
            while ((rd_ptr > n_deliv) && (exp_q.size() > 0)) begin
                void'(exp_q.pop_front());
                n_deliv++;
            end
            n_deliv        = rd_ptr;
            bbeat          = 0;
            first_pending  = 0;
            prev_mv_stall  = 0;
            prev_cmd_stall = 0;
        end else begin
            if (prev_mv_stall) begin
                chk("mvalid_hold", m_valid, 1);
                chk("mdata_hold", m_data, prev_md);
            end
            if (prev_cmd_stall) begin
                chk("cmd_hold_valid", cmd_valid, 1);
                chk("cmd_hold_addr", cmd_addr, prev_addr);
            end
            if (rd_en)
                chk("rd_en_occupancy", (rd_ptr - n_deliv - ((m_valid && m_ready) ? 1 : 0)) < 2, 1);
            if (cmd_valid && cmd_ready) begin
                if (exp_addr_q.size() == 0) chk("unexpected_cmd", 1, 0);
                else                        chk("cmd_addr", cmd_addr, exp_addr_q.pop_front());
                chk("cmd_len", cmd_len, 15);
                hs_cyc        = cyc;
                first_pending = 1;
            end
            if (m_valid && first_pending) begin
                // Handshake edge is hs_cyc+1; m_valid rises two edges later.
                chk("mvalid_latency", cyc - hs_cyc, 3);
                first_pending = 0;
            end
            if (m_valid) chk("m_last", m_last, bbeat == 15);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
                else                   chk("beat_data", m_data, exp_q.pop_front());
                if (bbeat == 0) first_cyc = cyc;
                n_deliv++;
                if (bbeat == 15) begin
                    last_cyc = cyc;
                    bbeat    = 0;
                    bursts_done++;
                end else begin
                    bbeat++;
                end
            end
            prev_mv_stall  = m_valid && !m_ready;
            prev_md        = m_data;
            prev_cmd_stall = cmd_valid && !cmd_ready;
            prev_addr      = cmd_addr;
        end
    end

    // Stimulus helpers: inputs change 2 time units after the rising edge.
    int next_val = 'hFF;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_words(input int n);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            v = next_val;
            mem[wr_ptr % 512] = {8{v}};
            exp_q.push_back({8{v}});
            wr_ptr++;
            next_val--;
        end
    endtask

    task automatic wait_bursts(input int target, input int budget, input bit rand_ready);
        int n;
        n = 0;
        while ((bursts_done < target) && (n < budget)) begin
            if (rand_ready) m_ready = pat[$urandom_range(0, 3)];
            tick();
            n++;
        end
        chk("burst_timeout", bursts_done >= target, 1);
        m_ready = 1'b1;
    endtask

    task automatic wait_beat(input int beat);
        int n;
        n = 0;
        while ((bbeat < beat) && (n < 200)) begin
            tick();
            n++;
        end
        chk("beat_timeout", bbeat >= beat, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_cmd_addr"}, cmd_addr, 0);
        chk({tag, "_cmd_len"}, cmd_len, 15);
    endtask

    bit bad;

    initial begin
        rst_n      = 1'b0;
        m_ready    = 1'b1;
        cmd_ready  = 1'b1;
        frame_sync = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Preloaded burst FF..F0 at full rate.
        exp_addr_q.push_back('h0);
        push_words(16);
        tick();
        chk("cmd_latency", cmd_valid, 1);
        chk("busy_active", busy, 1);
        wait_bursts(1, 200, 0);
        chk("throughput", last_cyc - first_cyc, 15);
        chk("next_addr_1", cmd_addr, 'h200);
        chk("busy_idle", busy, 0);

        // Level one short of a burst must not start anything.
        push_words(15);
        bad = 0;
        repeat (100) begin
            tick();
            if (cmd_valid || rd_en) bad = 1;
        end
        chk("level15_idle", bad, 0);

        // Complete it, with a stalling consumer; frame of 2 wraps to base.
        exp_addr_q.push_back('h200);
        push_words(1);
        wait_bursts(2, 600, 1);
        chk("frame_wrap", cmd_addr, 'h0);

        // Delayed command acceptance.
        cmd_ready = 1'b0;
        exp_addr_q.push_back('h0);
        push_words(16);
        repeat (4) tick();
        chk("cmd_waiting", cmd_valid, 1);
        cmd_ready = 1'b1;
        wait_bursts(3, 200, 0);
        chk("next_addr_3", cmd_addr, 'h200);

        // Frame sync on beat 5 of the burst at 0x200.
        exp_addr_q.push_back('h200);
        push_words(16);
        wait_beat(4);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        wait_bursts(4, 200, 0);
        chk("sync_addr_200", cmd_addr, 'h0);

        // Frame sync mid-burst at 0x0 overrides the increment to 0x200.
        exp_addr_q.push_back('h0);
        push_words(16);
        wait_beat(4);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        wait_bursts(5, 200, 0);
        chk("sync_addr_0", cmd_addr, 'h0);

        // Frame sync in IDLE applies immediately.
        exp_addr_q.push_back('h0);
        push_words(16);
        wait_bursts(6, 200, 0);
        chk("next_addr_6", cmd_addr, 'h200);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("idle_sync", cmd_addr, 'h0);

        // Reset on beat 8 abandons the burst.
        exp_addr_q.push_back('h0);
        push_words(16);
        wait_beat(8);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midburst_reset");
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            tick();
            if (rd_en || cmd_valid) bad = 1;
        end
        chk("post_reset_quiet", bad, 0);
        exp_addr_q.push_back('h0);
        push_words(16);
        wait_bursts(bursts_done + 1, 200, 0);
        chk("post_reset_next", cmd_addr, 'h200);
        chk("leftover_words", exp_q.size(), wr_ptr - rd_ptr);
        chk("addr_queue_empty", exp_addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
